// File: rtl/mcc_feeder.sv
// mcc_feeder: sequences one MCC job. It loads x words, then b entries, holds the DAC
// enable, waits for the MCC y write-back, and then requests the y readout.
// Optional build macro MCC_FEEDER_BLKCNT_EN enables the completed-block counter on
// blk_cnt. When the macro is undefined, blk_cnt is tied to zero.
module mcc_feeder #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES  = 35
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [10:0] x_count,
  input  logic [10:0] y_count,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [7:0]  host_data,
  input  logic [4:0]  host_diag,
  input  logic [4:0]  host_offset,
  input  logic        host_last,
  output logic [7:0]  x_values_out,
  output logic        x_values_valid_out,
  output logic [7:0]  b_value_out,
  output logic [4:0]  b_diag_out,
  output logic [4:0]  b_offset_out,
  output logic        block_valid_out,
  output logic        new_diagonal_out,
  output logic        dac_en_out,
  output logic        y_value_request_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] blk_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoadX  = 3'd1,
    StLoadB  = 3'd2,
    StSettle = 3'd3,
    StDrain  = 3'd4,
    StReadY  = 3'd5
  } state_e;

  localparam logic [10:0] SettleLoad = 11'(SETTLE_CYCLES);
  localparam logic [10:0] DrainLoad  = 11'(DRAIN_CYCLES);

  state_e      state_q, state_d;
  // Shared phase counter. It is loaded with a length and finishes the phase at 1.
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] y_cnt_q, y_cnt_d;
  logic        x_seen_q, x_seen_d;
  logic        first_b_q, first_b_d;
  logic [4:0]  prev_diag_q, prev_diag_d;

  logic [7:0]  x_data_q, x_data_d;
  logic        x_valid_q, x_valid_d;
  logic [7:0]  b_value_q, b_value_d;
  logic [4:0]  b_diag_q, b_diag_d;
  logic [4:0]  b_offset_q, b_offset_d;
  logic        blk_valid_q, blk_valid_d;
  logic        new_diag_q, new_diag_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;

  // Handshake and phase strobes decode straight from the state.
  always_comb begin
    host_ready          = (state_q == StLoadX) || (state_q == StLoadB);
    dac_en_out          = (state_q == StSettle);
    y_value_request_out = (state_q == StReadY);
    busy                = (state_q != StIdle);
    xfer                = host_valid && host_ready;
  end

  // Next-state logic and the registered stream outputs. The data outputs stay at zero
  // when there is no transfer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_cnt_d     = y_cnt_q;
    x_seen_d    = x_seen_q;
    first_b_d   = first_b_q;
    prev_diag_d = prev_diag_q;
    x_data_d    = '0;
    x_valid_d   = 1'b0;
    b_value_d   = '0;
    b_diag_d    = '0;
    b_offset_d  = '0;
    blk_valid_d = 1'b0;
    new_diag_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          y_cnt_d   = y_count;
          x_seen_d  = 1'b0;
          first_b_d = 1'b1;
          if (x_count != 11'd0) begin
            state_d = StLoadX;
            cnt_d   = x_count;
          end else begin
            state_d = StLoadB;
          end
        end
      end

      StLoadX: begin
        if (xfer) begin
          x_data_d  = host_data;
          x_valid_d = 1'b1;
          x_seen_d  = 1'b1;
          if (cnt_q == 11'd1) begin
            state_d = StLoadB;
          end else begin
            cnt_d = cnt_q - 11'd1;
          end
        end else if (x_seen_q) begin
          // The MCC needs the x burst without gaps, so a gap aborts the job.
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StLoadB: begin
        if (xfer) begin
          b_value_d   = host_data;
          b_diag_d    = host_diag;
          b_offset_d  = host_offset;
          blk_valid_d = 1'b1;
          new_diag_d  = first_b_q || (host_diag != prev_diag_q);
          prev_diag_d = host_diag;
          first_b_d   = 1'b0;
          if (host_last) begin
            state_d = StSettle;
            cnt_d   = SettleLoad;
          end
        end
      end

      StSettle: begin
        if (cnt_q == 11'd1) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      StDrain: begin
        if (cnt_q == 11'd1) begin
          if (y_cnt_q != 11'd0) begin
            state_d = StReadY;
            cnt_d   = y_cnt_q;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      StReadY: begin
        if (cnt_q == 11'd1) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers. Reset clears them asynchronously and aborts a job silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      y_cnt_q     <= '0;
      x_seen_q    <= 1'b0;
      first_b_q   <= 1'b0;
      prev_diag_q <= '0;
      x_data_q    <= '0;
      x_valid_q   <= 1'b0;
      b_value_q   <= '0;
      b_diag_q    <= '0;
      b_offset_q  <= '0;
      blk_valid_q <= 1'b0;
      new_diag_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_cnt_q     <= y_cnt_d;
      x_seen_q    <= x_seen_d;
      first_b_q   <= first_b_d;
      prev_diag_q <= prev_diag_d;
      x_data_q    <= x_data_d;
      x_valid_q   <= x_valid_d;
      b_value_q   <= b_value_d;
      b_diag_q    <= b_diag_d;
      b_offset_q  <= b_offset_d;
      blk_valid_q <= blk_valid_d;
      new_diag_q  <= new_diag_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign x_values_out       = x_data_q;
  assign x_values_valid_out = x_valid_q;
  assign b_value_out        = b_value_q;
  assign b_diag_out         = b_diag_q;
  assign b_offset_out       = b_offset_q;
  assign block_valid_out    = blk_valid_q;
  assign new_diagonal_out   = new_diag_q;
  assign done               = done_q;
  assign err                = err_q;

`ifdef MCC_FEEDER_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  // Completed-block counter. It advances on the edge that raises done, wraps at 0xFFFF,
  // and is cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt_q <= '0;
    end else if (done_d) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_mcc_feeder.sv
// Directed self-checking bench for mcc_feeder with SETTLE_CYCLES=4 and DRAIN_CYCLES=35.
module tb_mcc_feeder;

`ifdef MCC_FEEDER_BLKCNT_EN
  localparam bit BlkEn = 1'b1;
`else
  localparam bit BlkEn = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        start;
  logic [10:0] x_count;
  logic [10:0] y_count;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_data;
  logic [4:0]  host_diag;
  logic [4:0]  host_offset;
  logic        host_last;
  logic [7:0]  x_values_out;
  logic        x_values_valid_out;
  logic [7:0]  b_value_out;
  logic [4:0]  b_diag_out;
  logic [4:0]  b_offset_out;
  logic        block_valid_out;
  logic        new_diagonal_out;
  logic        dac_en_out;
  logic        y_value_request_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] blk_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int n;
  logic flag;

  mcc_feeder #(
    .SETTLE_CYCLES(4),
    .DRAIN_CYCLES (35)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .start              (start),
    .x_count            (x_count),
    .y_count            (y_count),
    .host_valid         (host_valid),
    .host_ready         (host_ready),
    .host_data          (host_data),
    .host_diag          (host_diag),
    .host_offset        (host_offset),
    .host_last          (host_last),
    .x_values_out       (x_values_out),
    .x_values_valid_out (x_values_valid_out),
    .b_value_out        (b_value_out),
    .b_diag_out         (b_diag_out),
    .b_offset_out       (b_offset_out),
    .block_valid_out    (block_valid_out),
    .new_diagonal_out   (new_diagonal_out),
    .dac_en_out         (dac_en_out),
    .y_value_request_out(y_value_request_out),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .blk_cnt            (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {13'd0, x_values_out, x_values_valid_out, b_value_out, b_diag_out, b_offset_out,
            block_valid_out, new_diagonal_out, dac_en_out, y_value_request_out, busy, done,
            err, host_ready, blk_cnt};
  endfunction

  task automatic put_b(input logic [4:0] d, input logic [4:0] o, input logic [7:0] v,
                       input logic l);
    host_valid  = 1'b1;
    host_diag   = d;
    host_offset = o;
    host_data   = v;
    host_last   = l;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; x_count = '0; y_count = '0;
    host_valid = 1'b0; host_data = '0; host_diag = '0; host_offset = '0; host_last = 1'b0;
    tick();
    tick();
    check("reset_outputs", all_outs(), 64'd0);
    rstn = 1'b1;
    tick();
    check("idle_after_reset", all_outs(), 64'd0);

    // Job 1: x = 11,22,33; three b entries; y_count = 2.
    start = 1'b1; x_count = 11'd3; y_count = 11'd2;
    tick();
    start = 1'b0;
    check("j1_busy", busy, 1);
    check("j1_ready_loadx", host_ready, 1);
    host_valid = 1'b1; host_data = 8'h11;
    tick();
    check("j1_x0", {x_values_valid_out, x_values_out}, {1'b1, 8'h11});
    host_data = 8'h22;
    tick();
    check("j1_x1", {x_values_valid_out, x_values_out}, {1'b1, 8'h22});
    host_data = 8'h33;
    tick();
    host_valid = 1'b0;
    check("j1_x2", {x_values_valid_out, x_values_out}, {1'b1, 8'h33});
    tick();
    check("j1_x_valid_off", x_values_valid_out, 0);
    check("j1_loadb_ready", host_ready, 1);
    check("j1_no_b_yet", block_valid_out, 0);

    put_b(5'd0, 5'd0, 8'h05, 1'b0);
    tick();
    check("j1_b0", {block_valid_out, new_diagonal_out, b_value_out, b_diag_out, b_offset_out},
          {1'b1, 1'b1, 8'h05, 5'd0, 5'd0});
    put_b(5'd0, 5'd1, 8'h06, 1'b0);
    tick();
    host_valid = 1'b0;
    check("j1_b1", {block_valid_out, new_diagonal_out, b_value_out, b_diag_out, b_offset_out},
          {1'b1, 1'b0, 8'h06, 5'd0, 5'd1});
    tick();
    check("j1_b_gap", block_valid_out, 0);
    put_b(5'd2, 5'd0, 8'h07, 1'b1);
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    check("j1_b2", {block_valid_out, new_diagonal_out, b_value_out, b_diag_out, b_offset_out},
          {1'b1, 1'b1, 8'h07, 5'd2, 5'd0});
    check("j1_ready_settle", host_ready, 0);

    n = 0;
    while (dac_en_out === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("j1_dac_cycles", n, 4);

    n = 0; flag = 1'b0;
    while (y_value_request_out !== 1'b1 && n < 200) begin
      flag = flag | dac_en_out | block_valid_out | x_values_valid_out | done | host_ready;
      n++;
      tick();
    end
    check("j1_drain_cycles", n, 35);
    check("j1_drain_idle", flag, 0);

    n = 0;
    while (y_value_request_out === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("j1_yreq_cycles", n, 2);
    check("j1_done", done, 1);
    check("j1_busy_end", busy, 0);
    check("j1_blk_cnt", blk_cnt, BlkEn ? 64'd1 : 64'd0);
    tick();
    check("j1_done_one_pulse", done, 0);

    // Job 2: gap after the second of four x words.
    start = 1'b1; x_count = 11'd4; y_count = 11'd1;
    tick();
    start = 1'b0;
    host_valid = 1'b1; host_data = 8'hA1;
    tick();
    host_data = 8'hA2;
    tick();
    host_valid = 1'b0;
    check("j2_x1", {x_values_valid_out, x_values_out}, {1'b1, 8'hA2});
    tick();
    check("j2_err", err, 1);
    check("j2_busy", busy, 0);
    check("j2_x_valid_drop", x_values_valid_out, 0);
    check("j2_no_b", block_valid_out, 0);
    tick();
    check("j2_err_pulse", err, 0);
    check("j2_no_done", done, 0);

    // Job 3: no x or y words, and a start pulse during SETTLE must be ignored.
    start = 1'b1; x_count = 11'd0; y_count = 11'd0;
    tick();
    start = 1'b0;
    check("j3_loadb_ready", host_ready, 1);
    put_b(5'd2, 5'd1, 8'h44, 1'b1);
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    check("j3_b_first_newdiag", {block_valid_out, new_diagonal_out, x_values_valid_out},
          {1'b1, 1'b1, 1'b0});
    check("j3_settle", dac_en_out, 1);
    start = 1'b1; x_count = 11'd5; y_count = 11'd3;
    tick();
    start = 1'b0;
    n = 1;
    while (dac_en_out === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("j3_dac_cycles", n, 4);
    n = 0; flag = 1'b0;
    while (done !== 1'b1 && n < 200) begin
      flag = flag | y_value_request_out | host_ready | x_values_valid_out;
      n++;
      tick();
    end
    check("j3_drain_to_done", n, 35);
    check("j3_no_yreq", flag, 0);
    check("j3_idle", busy, 0);
    check("j3_blk_cnt", blk_cnt, BlkEn ? 64'd2 : 64'd0);

    // Job 4: reset during READ_Y.
    tick();
    start = 1'b1; x_count = 11'd1; y_count = 11'd3;
    tick();
    start = 1'b0;
    host_valid = 1'b1; host_data = 8'h55;
    tick();
    put_b(5'd1, 5'd0, 8'h09, 1'b1);
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    n = 0;
    while (y_value_request_out !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("j4_reach_ready", n, 39);
    tick();
    rstn = 1'b0;
    #1;
    check("j4_reset_async", all_outs(), 64'd0);
    tick();
    check("j4_reset_hold", all_outs(), 64'd0);
    rstn = 1'b1;
    tick();
    check("j4_no_done_after_reset", {done, busy, err}, 3'b000);

    // Job 5: a normal job after the abort.
    start = 1'b1; x_count = 11'd0; y_count = 11'd1;
    tick();
    start = 1'b0;
    put_b(5'd0, 5'd0, 8'h01, 1'b1);
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    check("j5_b_newdiag", {block_valid_out, new_diagonal_out}, 2'b11);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("j5_cycles_to_done", n, 40);
    check("j5_blk_cnt", blk_cnt, BlkEn ? 64'd1 : 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mcc_feeder.md
MCC_FEEDER -- requirements
Module: mcc_feeder

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, number of cycles dac_en_out is held high per block (legal 1..255).
REQ-002 Parameter: DRAIN_CYCLES, default 35, wait cycles for MCC y write-back after settle (legal 1..255).
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a job; ignored unless the FSM is in IDLE.
REQ-006 x_count  in  11  number of x words to load (0..1024); sampled on an accepted start.
REQ-007 y_count  in  11  number of y words to request (0..1024); sampled on an accepted start.
REQ-008 host_valid / host_ready  in / out  1 / 1  host word handshake; transfer when both are high.
REQ-009 host_data  in  8  x value (LOAD_X) or b value (LOAD_B).
REQ-010 host_diag, host_offset  in  5 / 5  crossbar diagonal and offset of the b entry (LOAD_B only).
REQ-011 host_last  in  1  marks the final b entry of the block (LOAD_B only).
REQ-012 x_values_out, x_values_valid_out  out  8 / 1  x stream to the MCC.
REQ-013 b_value_out, b_diag_out, b_offset_out, block_valid_out, new_diagonal_out  out  8/5/5/1/1  b stream to the MCC.
REQ-014 dac_en_out, y_value_request_out  out  1 / 1  MCC DAC enable and y readout request.
REQ-015 busy, done, err  out  1 / 1 / 1  busy is high when not in IDLE; done and err are one-cycle pulses.
REQ-016 blk_cnt  out  16  count of completed blocks (see Configuration).

Function
REQ-017 FSM states: IDLE, LOAD_X, LOAD_B, SETTLE, DRAIN, READ_Y.
REQ-018 IDLE + start: go to LOAD_X if x_count != 0, else go to LOAD_B.
REQ-019 host_ready SHALL be a combinational function of state only: 1 in LOAD_X and LOAD_B, 0 otherwise.
REQ-020 LOAD_X: each transfer registers host_data to x_values_out with x_values_valid_out=1 in the next cycle (latency 1).
REQ-021 LOAD_X: after x_count transfers, go to LOAD_B; x_values_valid_out SHALL be high for exactly x_count contiguous cycles.
REQ-022 LOAD_X: host_valid=0 after the first transfer and before the last is a gap the MCC cannot tolerate; on a gap, pulse err, drop x_values_valid_out, and return to IDLE.
REQ-023 LOAD_B: each transfer registers b_value/diag/offset and pulses block_valid_out for 1 cycle in the next cycle.
REQ-024 LOAD_B: host_valid gaps are allowed; block_valid_out is 0 on cycles with no transfer.
REQ-025 new_diagonal_out SHALL be 1 alongside block_valid_out on the first entry of a block and on any entry whose host_diag differs from the previous entry's.
REQ-026 LOAD_B transfer with host_last=1: go to SETTLE on the next edge.
REQ-027 SETTLE: dac_en_out=1 for exactly SETTLE_CYCLES cycles, then go to DRAIN.
REQ-028 DRAIN: all outputs idle for DRAIN_CYCLES cycles, then go to READ_Y if y_count != 0, else finish.
REQ-029 READ_Y: y_value_request_out=1 for exactly y_count contiguous cycles, then finish.
REQ-030 Finish: pulse done for 1 cycle, increment blk_cnt, and return to IDLE.
REQ-031 A start pulse while busy SHALL be ignored with no side effects; x_count and y_count are not resampled.
REQ-032 All counters SHALL be 11 bits wide so that a value of 1024 does not wrap.

Reset
REQ-033 While rstn=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE; this includes host_ready, blk_cnt, and the previous-diagonal register.
REQ-034 Reset asserted mid-job SHALL abort the job immediately; no done or err pulse is produced.

Configuration
REQ-035 Macro MCC_FEEDER_BLKCNT_EN defined: blk_cnt is a 16-bit counter that wraps 0xFFFF->0 and is cleared only by reset.
REQ-036 Macro MCC_FEEDER_BLKCNT_EN undefined: no counter flops are instantiated; blk_cnt is tied to 0.

Verification
REQ-037 start, x_count=3, y_count=2, x words 0x11,0x22,0x33 back-to-back -> x_values_valid_out high 3 cycles with 0x11,0x22,0x33; then LOAD_B.
REQ-038 b entries (diag,off,val) = (0,0,0x05),(0,1,0x06),(2,0,0x07,last) -> 3 block_valid_out pulses; new_diagonal_out=1,0,1; then dac_en_out high 4 cycles.
REQ-039 DRAIN_CYCLES=35 -> y_value_request_out high 2 cycles starting 35 cycles after dac_en_out falls; done pulses once; blk_cnt=1.
REQ-040 x_count=4 with host_valid dropped after the 2nd word -> err pulses, busy=0, no block_valid_out pulse.
REQ-041 x_count=0, y_count=0 -> LOAD_X and READ_Y skipped, done follows DRAIN; start pulsed during SETTLE -> ignored.
REQ-042 rstn low during READ_Y -> all outputs 0 within the reset assertion; no done pulse; the next start runs a normal job.
